// File: rtl/edge_detection.sv
// Bounding-box finder: row pass yields top/bottom rows, column pass yields left/right columns.
// Optional macro EDGE_NOISE_FILTER_EN rejects foreground pixels that are not preceded by another in the same scan line.
module edge_detection #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter bit FG_DARK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [9:0]  iRow,
    input  logic [9:0]  iCol,
    input  logic        iHscan,
    input  logic        iVscan,
    input  logic [9:0]  dataBW,
    output logic [19:0] oRow,
    output logic [19:0] oCol,
    output logic [1:0]  ofinish
);

    localparam logic [9:0] LAST_ROW = 10'(V_RES - 1);
    localparam logic [9:0] LAST_COL = 10'(H_RES - 1);

    typedef enum logic [1:0] {
        ROW_SCAN = 2'd0,
        COL_SCAN = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [9:0]  top_r, bottom_r, left_r, right_r;
    logic [9:0]  top_nxt_s, bottom_nxt_s, left_nxt_s, right_nxt_s;
    logic        found_row_r, found_col_r, found_row_nxt_s, found_col_nxt_s;
    logic [19:0] orow_nxt_s, ocol_nxt_s;
    logic [1:0]  ofinish_nxt_s;
    logic        pix_fg_s, fg_s, frame_end_s;
    logic        row_smp_s, col_smp_s, row_hit_s, col_hit_s, row_done_s, col_done_s;
`ifdef EDGE_NOISE_FILTER_EN
    logic        run_r, run_nxt_s, line_start_s;
`endif

    // Sample qualification, optional run filter and min/max candidate computation
    always_comb begin
        pix_fg_s    = FG_DARK ? (dataBW == 10'h000) : (dataBW == 10'h3FF);
        frame_end_s = (iRow == LAST_ROW) && (iCol == LAST_COL);
        row_smp_s   = en && iHscan && !iVscan && (state_r == ROW_SCAN);
        col_smp_s   = en && iVscan && !iHscan && (state_r == COL_SCAN);
`ifdef EDGE_NOISE_FILTER_EN
        line_start_s = (state_r == ROW_SCAN) ? (iCol == 10'd0) : (iRow == 10'd0);
        fg_s         = pix_fg_s && run_r && !line_start_s;
        run_nxt_s    = (row_smp_s || col_smp_s) ? pix_fg_s : run_r;
`else
        fg_s         = pix_fg_s;
`endif
        row_hit_s  = row_smp_s && fg_s;
        col_hit_s  = col_smp_s && fg_s;
        row_done_s = row_smp_s && frame_end_s;
        col_done_s = col_smp_s && frame_end_s;

        found_row_nxt_s = found_row_r | row_hit_s;
        found_col_nxt_s = found_col_r | col_hit_s;
        top_nxt_s       = (row_hit_s && (iRow < top_r))    ? iRow : top_r;
        bottom_nxt_s    = (row_hit_s && (iRow > bottom_r)) ? iRow : bottom_r;
        left_nxt_s      = (col_hit_s && (iCol < left_r))   ? iCol : left_r;
        right_nxt_s     = (col_hit_s && (iCol > right_r))  ? iCol : right_r;

        // The frame-end sample is already folded into the *_nxt_s values used here
        orow_nxt_s = row_done_s ? (found_row_nxt_s ? {top_nxt_s, bottom_nxt_s} : {10'd0, LAST_ROW}) : oRow;
        ocol_nxt_s = col_done_s ? (found_col_nxt_s ? {left_nxt_s, right_nxt_s} : {10'd0, LAST_COL}) : oCol;
        ofinish_nxt_s = {(col_done_s ? 1'b1 : ofinish[1]), (row_done_s ? 1'b1 : ofinish[0])};
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ROW_SCAN: begin
                if (row_done_s) begin
                    state_nxt_s = COL_SCAN;
                end else begin
                    state_nxt_s = ROW_SCAN;
                end
            end
            COL_SCAN: begin
                if (col_done_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = COL_SCAN;
                end
            end
            DONE:    state_nxt_s = DONE;
            default: state_nxt_s = ROW_SCAN;
        endcase
    end

    // State, extrema and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ROW_SCAN;
            top_r       <= 10'h3FF;
            bottom_r    <= 10'h000;
            left_r      <= 10'h3FF;
            right_r     <= 10'h000;
            found_row_r <= 1'b0;
            found_col_r <= 1'b0;
            oRow        <= 20'd0;
            oCol        <= 20'd0;
            ofinish     <= 2'b00;
`ifdef EDGE_NOISE_FILTER_EN
            run_r       <= 1'b0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            top_r       <= top_nxt_s;
            bottom_r    <= bottom_nxt_s;
            left_r      <= left_nxt_s;
            right_r     <= right_nxt_s;
            found_row_r <= found_row_nxt_s;
            found_col_r <= found_col_nxt_s;
            oRow        <= orow_nxt_s;
            oCol        <= ocol_nxt_s;
            ofinish     <= ofinish_nxt_s;
`ifdef EDGE_NOISE_FILTER_EN
            run_r       <= run_nxt_s;
`endif
        end
    end

endmodule

// File: tb/tb_edge_detection.sv
// Directed bench for edge_detection on a reduced 64x56 frame so full passes stay short.
module tb_edge_detection;

    localparam int H = 64;
    localparam int V = 56;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [9:0]  iRow, iCol, dataBW;
    logic        iHscan, iVscan;
    logic [19:0] oRow, oCol;
    logic [1:0]  ofinish;

    int n_cmp = 0;
    int n_err = 0;

    edge_detection #(.H_RES(H), .V_RES(V), .FG_DARK(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .iRow(iRow), .iCol(iCol),
        .iHscan(iHscan), .iVscan(iVscan), .dataBW(dataBW),
        .oRow(oRow), .oCol(oCol), .ofinish(ofinish)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit e, input int r, input int c, input bit h, input bit v, input bit dark);
        en     = e;
        iRow   = 10'(r);
        iCol   = 10'(c);
        iHscan = h;
        iVscan = v;
        dataBW = dark ? 10'h000 : 10'h3FF;
        @(posedge clk);
        #1;
    endtask

    function automatic bit fg_at(input int pat, input int r, input int c);
        case (pat)
            1:       return (r >= 10 && r <= 20 && c >= 30 && c <= 35);
            2:       return (r == 0 && c == 0) || (r == V-1 && c == H-1);
            3:       return (r == 10 && c == 10) || (r >= 50 && r <= 54 && c >= 50 && c <= 54);
            default: return 1'b0;
        endcase
    endfunction

    // One pass; stall_row >= 0 inserts a 1000-cycle en=0 stall with dark data, max_n limits samples.
    task automatic run_pass(input bit col, input int pat, input int stall_row, input int max_n);
        int n;
        int r;
        int c;
        n = 0;
        for (int a = 0; a < (col ? H : V); a++) begin
            for (int b = 0; b < (col ? V : H); b++) begin
                r = col ? b : a;
                c = col ? a : b;
                if (n == max_n) return;
                if (!col && r == stall_row && c == 0) begin
                    for (int k = 0; k < 1000; k++) drive(1'b0, r, c, 1'b1, 1'b0, 1'b1);
                    check("stall_orow", oRow, 20'd0);
                    check("stall_ofinish", {18'd0, ofinish}, 20'd0);
                end
                drive(1'b1, r, c, !col, col, fg_at(pat, r, c));
                n++;
            end
        end
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b0;
        #1;
        check({tag, "_orow"}, oRow, 20'd0);
        check({tag, "_ocol"}, oCol, 20'd0);
        check({tag, "_ofinish"}, {18'd0, ofinish}, 20'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; iRow = 10'd0; iCol = 10'd0;
        iHscan = 1'b0; iVscan = 1'b0; dataBW = 10'h3FF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_orow", oRow, 20'd0);
        check("rst_ocol", oCol, 20'd0);
        check("rst_ofinish", {18'd0, ofinish}, 20'd0);
        rst = 1'b1;

        // Rectangle rows 10..20, cols 30..35
        run_pass(1'b0, 1, -1, -1);
        check("rect_fin0", {18'd0, ofinish}, 20'd1);
        check("rect_orow", oRow, {10'd10, 10'd20});
        check("rect_ocol_idle", oCol, 20'd0);
        run_pass(1'b1, 1, -1, -1);
        check("rect_fin1", {18'd0, ofinish}, 20'd3);
        check("rect_ocol", oCol, {10'd30, 10'd35});
        check("rect_orow_hold", oRow, {10'd10, 10'd20});

        // DONE ignores further samples, including dark frame-end ones
        drive(1'b1, V-1, H-1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 0, 0, 1'b0, 1'b1, 1'b1);
        check("done_orow", oRow, {10'd10, 10'd20});
        check("done_ocol", oCol, {10'd30, 10'd35});
        check("done_fin", {18'd0, ofinish}, 20'd3);

        // Corner pixels: last sample of each pass must be processed
        pulse_reset("rst1");
        run_pass(1'b0, 2, -1, -1);
        check("corner_orow", oRow, {10'd0, 10'd55});
        run_pass(1'b1, 2, -1, -1);
        check("corner_ocol", oCol, {10'd0, 10'd63});
        check("corner_fin", {18'd0, ofinish}, 20'd3);

        // All-white frame, with illegal-flag dark samples injected first
        pulse_reset("rst2");
        drive(1'b1, V-1, H-1, 1'b1, 1'b1, 1'b1);
        drive(1'b1, V-1, H-1, 1'b0, 1'b1, 1'b1);
        check("badflag_fin", {18'd0, ofinish}, 20'd0);
        run_pass(1'b0, 0, -1, -1);
        check("white_orow", oRow, {10'd0, 10'd55});
        check("white_fin0", {18'd0, ofinish}, 20'd1);
        drive(1'b1, V-1, H-1, 1'b1, 1'b0, 1'b1);
        check("wrongflag_fin", {18'd0, ofinish}, 20'd1);
        run_pass(1'b1, 0, -1, -1);
        check("white_ocol", oCol, {10'd0, 10'd63});
        check("white_fin1", {18'd0, ofinish}, 20'd3);

        // Rectangle again with an en=0 stall mid row scan
        pulse_reset("rst3");
        run_pass(1'b0, 1, 5, -1);
        check("stall_orow_end", oRow, {10'd10, 10'd20});
        run_pass(1'b1, 1, -1, -1);
        check("stall_ocol_end", oCol, {10'd30, 10'd35});
        check("stall_fin_end", {18'd0, ofinish}, 20'd3);

        // Reset in the middle of the column scan, then a fresh run
        pulse_reset("rst4");
        run_pass(1'b0, 1, -1, -1);
        run_pass(1'b1, 1, -1, 1800);
        check("mid_fin", {18'd0, ofinish}, 20'd1);
        pulse_reset("midcol");
        run_pass(1'b0, 1, -1, -1);
        run_pass(1'b1, 1, -1, -1);
        check("fresh_orow", oRow, {10'd10, 10'd20});
        check("fresh_ocol", oCol, {10'd30, 10'd35});
        check("fresh_fin", {18'd0, ofinish}, 20'd3);

        // Isolated pixel plus 5x5 block
        pulse_reset("rst5");
        run_pass(1'b0, 3, -1, -1);
        run_pass(1'b1, 3, -1, -1);
`ifdef EDGE_NOISE_FILTER_EN
        check("noise_orow", oRow, {10'd50, 10'd54});
        check("noise_ocol", oCol, {10'd50, 10'd54});
`else
        check("noise_orow", oRow, {10'd10, 10'd54});
        check("noise_ocol", oCol, {10'd10, 10'd54});
`endif
        check("noise_fin", {18'd0, ofinish}, 20'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
